// File: rtl/rob_commit_if.sv
// Head-of-ROB view and retire-side controls shared by the commit controller and its environment.
// master: the commit controller; slave: ROB, register file, memory and predictor side.
interface rob_commit_if #(
   parameter int unsigned data_width = 16,
   parameter int unsigned tag_width  = 3
);
   localparam int unsigned inst_width = 4;
   localparam int unsigned reg_width  = 3;
   localparam int unsigned hist_width = 4;

   logic                    rob_empty;
   logic                    head_valid;
   logic [inst_width-1:0]   head_inst;
   logic [reg_width-1:0]    head_dest;
   logic [data_width-1:0]   head_value;
   logic                    head_predict;
   logic [data_width-1:0]   head_orig_pc;
   logic [hist_width-1:0]   head_bht;
   logic [tag_width-1:0]    head_tag;
   logic                    st_done;

   logic                    rob_re;
   logic                    rf_we;
   logic [reg_width-1:0]    rf_dest;
   logic [data_width-1:0]   rf_data;
   logic [tag_width-1:0]    rf_tag;
   logic                    st_commit;
   logic                    flush;
   logic [data_width-1:0]   redirect_pc;
   logic                    bht_we;
   logic [data_width-1:0]   bht_pc;
   logic [hist_width-1:0]   bht_hist;
   logic                    bht_taken;

   modport master (
      input  rob_empty, head_valid, head_inst, head_dest, head_value, head_predict,
             head_orig_pc, head_bht, head_tag, st_done,
      output rob_re, rf_we, rf_dest, rf_data, rf_tag, st_commit, flush, redirect_pc,
             bht_we, bht_pc, bht_hist, bht_taken
   );

   modport slave (
      output rob_empty, head_valid, head_inst, head_dest, head_value, head_predict,
             head_orig_pc, head_bht, head_tag, st_done,
      input  rob_re, rf_we, rf_dest, rf_data, rf_tag, st_commit, flush, redirect_pc,
             bht_we, bht_pc, bht_hist, bht_taken
   );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order ROB commit controller for LC-3b: retires one head entry per cycle, sequences stores and branch flushes.
// Optional feature macro COMMIT_STATS_EN adds retire_count / mispredict_count statistics outputs.
module rob_commit_ctrl #(
   parameter int unsigned data_width = 16,
   parameter int unsigned tag_width  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   rob_commit_if.master     bus
`ifdef COMMIT_STATS_EN
   ,
   output logic [15:0]      retire_count,
   output logic [15:0]      mispredict_count
`endif
);
   localparam int unsigned reg_width  = 3;
   localparam int unsigned hist_width = 4;
   localparam int unsigned op_width   = 4;

   localparam logic [op_width-1:0] op_br   = 4'b0000;
   localparam logic [op_width-1:0] op_add  = 4'b0001;
   localparam logic [op_width-1:0] op_ldb  = 4'b0010;
   localparam logic [op_width-1:0] op_stb  = 4'b0011;
   localparam logic [op_width-1:0] op_jsr  = 4'b0100;
   localparam logic [op_width-1:0] op_and  = 4'b0101;
   localparam logic [op_width-1:0] op_ldr  = 4'b0110;
   localparam logic [op_width-1:0] op_str  = 4'b0111;
   localparam logic [op_width-1:0] op_rti  = 4'b1000;
   localparam logic [op_width-1:0] op_not  = 4'b1001;
   localparam logic [op_width-1:0] op_ldi  = 4'b1010;
   localparam logic [op_width-1:0] op_sti  = 4'b1011;
   localparam logic [op_width-1:0] op_jmp  = 4'b1100;
   localparam logic [op_width-1:0] op_shf  = 4'b1101;
   localparam logic [op_width-1:0] op_lea  = 4'b1110;
   localparam logic [op_width-1:0] op_trap = 4'b1111;

   typedef enum logic [1:0] {
      COMMIT  = 2'd0,
      WAIT_ST = 2'd1,
      FLUSH   = 2'd2
   } state_e;

   state_e state, state_nxt;

   logic                   rob_re_c;
   logic                   rf_we_c;
   logic [reg_width-1:0]   rf_dest_c;
   logic [data_width-1:0]  rf_data_c;
   logic [tag_width-1:0]   rf_tag_c;
   logic                   st_commit_c;
   logic                   flush_c;
   logic [data_width-1:0]  redirect_pc_c;
   logic                   bht_we_c;
   logic [data_width-1:0]  bht_pc_c;
   logic [hist_width-1:0]  bht_hist_c;
   logic                   bht_taken_c;
   logic                   br_taken;
   logic                   head_ready;

   // A branch is taken whenever its resolved next-PC is not the fall-through address.
   assign br_taken   = (bus.head_value != data_width'(bus.head_orig_pc + data_width'(2)));
   assign head_ready = !bus.rob_empty && bus.head_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COMMIT;
      else        state <= state_nxt;
   end

   // Next state and same-cycle retire controls.
   always_comb begin
      state_nxt     = state;
      rob_re_c      = 1'b0;
      rf_we_c       = 1'b0;
      rf_dest_c     = '0;
      rf_data_c     = '0;
      rf_tag_c      = '0;
      st_commit_c   = 1'b0;
      flush_c       = 1'b0;
      redirect_pc_c = '0;
      bht_we_c      = 1'b0;
      bht_pc_c      = '0;
      bht_hist_c    = '0;
      bht_taken_c   = 1'b0;

      unique case (state)
         COMMIT: begin
            if (head_ready) begin
               unique case (bus.head_inst)
                  op_stb, op_str, op_sti: begin
                     st_commit_c = 1'b1;
                     state_nxt   = WAIT_ST;
                  end
                  op_br: begin
                     rob_re_c    = 1'b1;
                     bht_we_c    = 1'b1;
                     bht_pc_c    = bus.head_orig_pc;
                     bht_hist_c  = bus.head_bht;
                     bht_taken_c = br_taken;
                     if (br_taken != bus.head_predict) begin
                        flush_c       = 1'b1;
                        redirect_pc_c = bus.head_value;
                        state_nxt     = FLUSH;
                     end
                  end
                  op_jmp, op_jsr: begin
                     rob_re_c      = 1'b1;
                     flush_c       = 1'b1;
                     redirect_pc_c = bus.head_value;
                     state_nxt     = FLUSH;
                     if (bus.head_inst == op_jsr) begin
                        rf_we_c   = 1'b1;
                        rf_dest_c = bus.head_dest;
                        rf_data_c = bus.head_value;
                        rf_tag_c  = bus.head_tag;
                     end
                  end
                  op_rti: rob_re_c = 1'b1;
                  op_add, op_and, op_not, op_ldr, op_ldb, op_ldi, op_lea, op_shf, op_trap: begin
                     rob_re_c  = 1'b1;
                     rf_we_c   = 1'b1;
                     rf_dest_c = bus.head_dest;
                     rf_data_c = bus.head_value;
                     rf_tag_c  = bus.head_tag;
                  end
                  default: ;
               endcase
            end
         end
         WAIT_ST: begin
            st_commit_c = 1'b1;
            if (bus.st_done) begin
               rob_re_c  = 1'b1;
               state_nxt = COMMIT;
            end
         end
         FLUSH:   state_nxt = COMMIT;
         default: state_nxt = COMMIT;
      endcase
   end

   // Reset silences every output immediately, independent of the clock.
   assign bus.rob_re      = rst_n & rob_re_c;
   assign bus.rf_we       = rst_n & rf_we_c;
   assign bus.rf_dest     = rst_n ? rf_dest_c     : '0;
   assign bus.rf_data     = rst_n ? rf_data_c     : '0;
   assign bus.rf_tag      = rst_n ? rf_tag_c      : '0;
   assign bus.st_commit   = rst_n & st_commit_c;
   assign bus.flush       = rst_n & flush_c;
   assign bus.redirect_pc = rst_n ? redirect_pc_c : '0;
   assign bus.bht_we      = rst_n & bht_we_c;
   assign bus.bht_pc      = rst_n ? bht_pc_c      : '0;
   assign bus.bht_hist    = rst_n ? bht_hist_c    : '0;
   assign bus.bht_taken   = rst_n & bht_taken_c;

`ifdef COMMIT_STATS_EN
   // Free-running 16-bit statistics, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count     <= 16'd0;
         mispredict_count <= 16'd0;
      end else begin
         if (rob_re_c) retire_count     <= retire_count + 16'd1;
         if (flush_c)  mispredict_count <= mispredict_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed table, multi-cycle corner sequences and a randomized model check.
module tb_rob_commit_ctrl;
   localparam int unsigned DW = 16;
   localparam int unsigned TW = 3;

   localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_STB = 4'h3, OP_JSR  = 4'h4;
   localparam logic [3:0] OP_STR = 4'h7, OP_RTI = 4'h8, OP_NOT = 4'h9, OP_STI  = 4'hB;
   localparam logic [3:0] OP_JMP = 4'hC, OP_LDR = 4'h6, OP_TRAP = 4'hF;

   typedef struct packed {
      logic        rob_empty;
      logic        head_valid;
      logic [3:0]  inst;
      logic [2:0]  dest;
      logic [15:0] value;
      logic        predict;
      logic [15:0] orig_pc;
      logic [3:0]  bht;
      logic [2:0]  tag;
      logic        st_done;
   } in_t;

   typedef struct packed {
      logic        rob_re;
      logic        rf_we;
      logic [2:0]  rf_dest;
      logic [15:0] rf_data;
      logic [2:0]  rf_tag;
      logic        st_commit;
      logic        flush;
      logic [15:0] redirect_pc;
      logic        bht_we;
      logic [15:0] bht_pc;
      logic [3:0]  bht_hist;
      logic        bht_taken;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   m_wait = 1'b0;
   bit   m_bubble = 1'b0;

   always #5 clk = ~clk;

   rob_commit_if #(.data_width(DW), .tag_width(TW)) bus ();

`ifdef COMMIT_STATS_EN
   logic [15:0] retire_count, mispredict_count;
`endif

   rob_commit_ctrl #(.data_width(DW), .tag_width(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef COMMIT_STATS_EN
      ,
      .retire_count     (retire_count),
      .mispredict_count (mispredict_count)
`endif
   );

   function automatic out_t get_out();
      out_t o;
      o.rob_re = bus.rob_re;       o.rf_we = bus.rf_we;         o.rf_dest = bus.rf_dest;
      o.rf_data = bus.rf_data;     o.rf_tag = bus.rf_tag;       o.st_commit = bus.st_commit;
      o.flush = bus.flush;         o.redirect_pc = bus.redirect_pc;
      o.bht_we = bus.bht_we;       o.bht_pc = bus.bht_pc;       o.bht_hist = bus.bht_hist;
      o.bht_taken = bus.bht_taken;
      return o;
   endfunction

   task automatic drive(input in_t i);
      bus.rob_empty = i.rob_empty;   bus.head_valid = i.head_valid; bus.head_inst = i.inst;
      bus.head_dest = i.dest;        bus.head_value = i.value;      bus.head_predict = i.predict;
      bus.head_orig_pc = i.orig_pc;  bus.head_bht = i.bht;          bus.head_tag = i.tag;
      bus.st_done = i.st_done;
   endtask

   task automatic check(input string name, input int idx, input out_t exp);
      out_t got;
      got = get_out();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
      end
   endtask

   // Drive just after the falling edge, compare before the rising edge, return at the next falling edge.
   task automatic step(input in_t i, input out_t e, input string name, input int idx);
      drive(i);
      #1;
      check(name, idx, e);
      @(negedge clk);
   endtask

   function automatic in_t hd(input logic [3:0] inst, input logic [2:0] dest, input logic [15:0] value,
                              input logic [2:0] tag, input logic [15:0] pc, input logic pred,
                              input logic [3:0] bht);
      in_t r = '0;
      r.head_valid = 1'b1; r.inst = inst; r.dest = dest; r.value = value;
      r.tag = tag; r.orig_pc = pc; r.predict = pred; r.bht = bht;
      return r;
   endfunction

   function automatic out_t o_wr(input logic [2:0] d, input logic [15:0] v, input logic [2:0] t);
      out_t o = '0;
      o.rob_re = 1'b1; o.rf_we = 1'b1; o.rf_dest = d; o.rf_data = v; o.rf_tag = t;
      return o;
   endfunction

   function automatic out_t o_br(input logic [15:0] pc, input logic [3:0] h, input logic tk);
      out_t o = '0;
      o.rob_re = 1'b1; o.bht_we = 1'b1; o.bht_pc = pc; o.bht_hist = h; o.bht_taken = tk;
      return o;
   endfunction

   function automatic out_t o_fl(input logic [15:0] target);
      out_t o = '0;
      o.rob_re = 1'b1; o.flush = 1'b1; o.redirect_pc = target;
      return o;
   endfunction

   function automatic out_t o_st(input logic re);
      out_t o = '0;
      o.st_commit = 1'b1; o.rob_re = re;
      return o;
   endfunction

   // Reference model: what commit should do this cycle given the pending store / flush bubble.
   function automatic out_t model_out(input in_t i);
      out_t o = '0;
      int   fallthru;
      bit   taken;
      if (m_bubble) return o;
      if (m_wait) begin
         o.st_commit = 1'b1;
         o.rob_re    = i.st_done;
         return o;
      end
      if (i.rob_empty || !i.head_valid) return o;
      fallthru = (int'(i.orig_pc) + 2) % 65536;
      taken    = (int'(i.value) != fallthru);
      if (i.inst inside {OP_STB, OP_STR, OP_STI}) begin
         o.st_commit = 1'b1;
      end else if (i.inst == OP_BR) begin
         o = o_br(i.orig_pc, i.bht, taken);
         if (taken != i.predict) o = o | o_fl(i.value);
      end else if (i.inst == OP_JMP) begin
         o = o_fl(i.value);
      end else if (i.inst == OP_JSR) begin
         o = o_wr(i.dest, i.value, i.tag) | o_fl(i.value);
      end else if (i.inst == OP_RTI) begin
         o.rob_re = 1'b1;
      end else begin
         o = o_wr(i.dest, i.value, i.tag);
      end
      return o;
   endfunction

   function automatic void model_step(input in_t i, input out_t e);
      if (m_bubble) m_bubble = 1'b0;
      else if (m_wait) begin
         if (i.st_done) m_wait = 1'b0;
      end else if (!i.rob_empty && i.head_valid) begin
         if (i.inst inside {OP_STB, OP_STR, OP_STI}) m_wait = 1'b1;
         else if (e.flush) m_bubble = 1'b1;
      end
   endfunction

   vec_t tbl[17];

   initial begin
      in_t  in;
      out_t e;

      tbl[0]  = '{hd(OP_ADD, 3'd3, 16'h1234, 3'd2, 16'h3000, 1'b0, 4'h0), o_wr(3'd3, 16'h1234, 3'd2)};
      tbl[1]  = '{hd(OP_ADD, 3'd3, 16'h1234, 3'd2, 16'h3000, 1'b0, 4'h0), '0};
      tbl[1].i.rob_empty = 1'b1;
      tbl[2]  = '{hd(OP_ADD, 3'd3, 16'h1234, 3'd2, 16'h3000, 1'b0, 4'h0), '0};
      tbl[2].i.head_valid = 1'b0;
      tbl[3]  = '{hd(OP_BR, 3'd0, 16'h3002, 3'd1, 16'h3000, 1'b0, 4'h5), o_br(16'h3000, 4'h5, 1'b0)};
      tbl[4]  = '{hd(OP_BR, 3'd0, 16'h3010, 3'd1, 16'h3000, 1'b1, 4'hA), o_br(16'h3000, 4'hA, 1'b1)};
      tbl[5]  = '{hd(OP_BR, 3'd0, 16'h3010, 3'd1, 16'h3000, 1'b0, 4'h3),
                  o_br(16'h3000, 4'h3, 1'b1) | o_fl(16'h3010)};
      tbl[6]  = '{hd(OP_ADD, 3'd1, 16'h5555, 3'd4, 16'h3010, 1'b0, 4'h0), '0};
      tbl[7]  = '{hd(OP_ADD, 3'd1, 16'h5555, 3'd4, 16'h3010, 1'b0, 4'h0), o_wr(3'd1, 16'h5555, 3'd4)};
      tbl[8]  = '{hd(OP_BR, 3'd0, 16'h4002, 3'd3, 16'h4000, 1'b1, 4'hC),
                  o_br(16'h4000, 4'hC, 1'b0) | o_fl(16'h4002)};
      tbl[9]  = '{hd(OP_LDR, 3'd5, 16'h0BAD, 3'd4, 16'h4002, 1'b0, 4'h0), '0};
      tbl[10] = '{hd(OP_JMP, 3'd0, 16'h2000, 3'd5, 16'h1000, 1'b0, 4'h0), o_fl(16'h2000)};
      tbl[11] = '{hd(OP_ADD, 3'd2, 16'h7777, 3'd6, 16'h2000, 1'b0, 4'h0), '0};
      tbl[12] = '{hd(OP_JSR, 3'd7, 16'h2400, 3'd6, 16'h2000, 1'b0, 4'h0),
                  o_wr(3'd7, 16'h2400, 3'd6) | o_fl(16'h2400)};
      tbl[13] = '{hd(OP_ADD, 3'd2, 16'h7777, 3'd7, 16'h2400, 1'b0, 4'h0), '0};
      tbl[14] = '{hd(OP_NOT, 3'd2, 16'hFFFF, 3'd0, 16'h2400, 1'b0, 4'h0), o_wr(3'd2, 16'hFFFF, 3'd0)};
      tbl[14].i.st_done = 1'b1;
      tbl[15] = '{hd(OP_BR, 3'd0, 16'h0000, 3'd1, 16'hFFFE, 1'b0, 4'h1), o_br(16'hFFFE, 4'h1, 1'b0)};
      tbl[16] = '{hd(OP_TRAP, 3'd7, 16'h0202, 3'd5, 16'h0000, 1'b0, 4'h0), o_wr(3'd7, 16'h0202, 3'd5)};

      // Reset holds outputs low even with a retirable head present.
      drive(tbl[0].i);
      #12;
      check("reset", 0, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 17; k++) step(tbl[k].i, tbl[k].e, "table", k);

      // Store with st_done three cycles later.
      for (int c = 0; c < 4; c++) begin
         in = hd(OP_STR, 3'd0, 16'h0040, 3'd1, 16'h3004, 1'b0, 4'h0);
         in.st_done = (c == 3);
         step(in, o_st(c == 3), "store", c);
      end
      step(hd(OP_ADD, 3'd4, 16'h0011, 3'd2, 16'h3006, 1'b0, 4'h0), o_wr(3'd4, 16'h0011, 3'd2), "store_after", 0);

      // st_done already high when the store reaches the head: first cycle only requests.
      in = hd(OP_STB, 3'd0, 16'h0041, 3'd3, 16'h3008, 1'b0, 4'h0);
      in.st_done = 1'b1;
      step(in, o_st(1'b0), "st_early", 0);
      step(in, o_st(1'b1), "st_early", 1);

      // Reset during WAIT_ST abandons the store.
      in = hd(OP_STI, 3'd0, 16'h0042, 3'd4, 16'h300A, 1'b0, 4'h0);
      step(in, o_st(1'b0), "rst_wait", 0);
      in.st_done = 1'b1;
      drive(in);
      rst_n = 1'b0;
      #1;
      check("rst_wait", 1, '0);
      @(negedge clk);
      check("rst_wait", 2, '0);
      rst_n = 1'b1;
      step(hd(OP_ADD, 3'd6, 16'hBEEF, 3'd1, 16'h300C, 1'b0, 4'h0), o_wr(3'd6, 16'hBEEF, 3'd1), "post_rst", 0);

      // Reset during the flush bubble returns straight to retiring.
      step(hd(OP_BR, 3'd0, 16'h3100, 3'd2, 16'h300E, 1'b0, 4'h7),
           o_br(16'h300E, 4'h7, 1'b1) | o_fl(16'h3100), "rst_flush", 0);
      drive(hd(OP_ADD, 3'd5, 16'hCAFE, 3'd3, 16'h3100, 1'b0, 4'h0));
      rst_n = 1'b0;
      #1;
      check("rst_flush", 1, '0);
      @(negedge clk);
      rst_n = 1'b1;
      step(hd(OP_ADD, 3'd5, 16'hCAFE, 3'd3, 16'h3100, 1'b0, 4'h0), o_wr(3'd5, 16'hCAFE, 3'd3), "rst_flush", 2);

`ifdef COMMIT_STATS_EN
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (retire_count !== 16'd0 || mispredict_count !== 16'd0) begin
         n_bad++;
         $display("FAIL stats_reset: got %h/%h expected 0/0", retire_count, mispredict_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(hd(OP_ADD, 3'd1, 16'h0001, 3'd0, 16'h3000, 1'b0, 4'h0), o_wr(3'd1, 16'h0001, 3'd0), "stats", 0);
      step(hd(OP_BR, 3'd0, 16'h3010, 3'd1, 16'h3002, 1'b0, 4'h0),
           o_br(16'h3002, 4'h0, 1'b1) | o_fl(16'h3010), "stats", 1);
      step(hd(OP_ADD, 3'd1, 16'h0002, 3'd2, 16'h3010, 1'b0, 4'h0), '0, "stats", 2);
      step(hd(OP_ADD, 3'd1, 16'h0002, 3'd2, 16'h3010, 1'b0, 4'h0), o_wr(3'd1, 16'h0002, 3'd2), "stats", 3);
      n_vec++;
      if (retire_count !== 16'd3 || mispredict_count !== 16'd1) begin
         n_bad++;
         $display("FAIL stats_count: got %0d/%0d expected 3/1", retire_count, mispredict_count);
      end
`endif

      // Randomized traffic against the reference model.
      m_wait   = 1'b0;
      m_bubble = 1'b0;
      for (int k = 0; k < 600; k++) begin
         in            = '0;
         in.rob_empty  = ($urandom_range(0, 7) == 0);
         in.head_valid = ($urandom_range(0, 3) != 0);
         in.inst       = 4'($urandom);
         in.dest       = 3'($urandom);
         in.tag        = 3'($urandom);
         in.orig_pc    = 16'($urandom) & 16'hFFFE;
         in.value      = ($urandom_range(0, 1) == 1) ? 16'(in.orig_pc + 16'd2) : 16'($urandom);
         in.predict    = 1'($urandom);
         in.bht        = 4'($urandom);
         in.st_done    = ($urandom_range(0, 2) == 0);
         e = model_out(in);
         step(in, e, "rand", k);
         model_step(in, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
